// File: rtl/pipe_buf_pkg.sv
// Shared types and helpers for the parametrised pipeline-stage buffer.
// The state encoding is fixed so that existing debug tooling keeps working.
package pipe_buf_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;

  function automatic int unsigned calc_dw(input int unsigned width, input int unsigned fields);
    return width * fields;
  endfunction

endpackage

// File: rtl/pipe_stage_buffer_sat_counter.sv
// Saturating up-counter. It sticks at all-ones and is cleared only by reset.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             INC,
  output logic [CNT_W-1:0] COUNT
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (INC && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign COUNT = count_q;

endmodule

// File: rtl/pipe_stage_buffer.sv
// Valid/ready pipeline-stage register carrying FIELDS packed fields of WIDTH bits,
// with synchronous flush, an optional two-entry skid mode and a saturating stall counter.
module pipe_stage_buffer
  import pipe_buf_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned FIELDS = 5,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                                CLK,
  input  logic                                RST_N,
  input  logic                                FLUSH,
  input  logic                                IN_VALID,
  output logic                                IN_READY,
  input  logic [calc_dw(WIDTH, FIELDS)-1:0]   IN_DATA,
  output logic                                OUT_VALID,
  input  logic                                OUT_READY,
  output logic [calc_dw(WIDTH, FIELDS)-1:0]   OUT_DATA,
  output logic [CNT_W-1:0]                    STALL_CNT
);

  localparam int unsigned DW = calc_dw(WIDTH, FIELDS);

  buf_state_e    state_q, state_d;
  logic [DW-1:0] main_q, main_d;
  logic [DW-1:0] skid_data;
  logic          skid_load;
  logic          acc;
  logic          pop;
  logic          stall_inc;

  assign OUT_VALID = (state_q != ST_EMPTY);
  assign OUT_DATA  = main_q;
  assign acc       = IN_VALID & IN_READY;
  assign pop       = OUT_VALID & OUT_READY;
  assign stall_inc = OUT_VALID & ~OUT_READY;

  always_comb begin
    state_d   = state_q;
    main_d    = main_q;
    skid_load = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (acc) begin
          state_d = ST_ONE;
          main_d  = IN_DATA;
        end
      end
      ST_ONE: begin
        if (acc && pop) begin
          main_d = IN_DATA;
        end else if (acc && (SKID != 0)) begin
          state_d   = ST_FULL;
          skid_load = 1'b1;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          state_d = ST_ONE;
          main_d  = skid_data;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush applied last: handshakes in this cycle complete upstream but never reach storage.
    if (FLUSH) begin
      state_d   = ST_EMPTY;
      main_d    = main_q;
      skid_load = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic [DW-1:0] skid_q, skid_d;
      logic          ready_q, ready_d;

      // Ready is registered from the next state so it never depends on OUT_READY combinationally.
      always_comb begin
        skid_d  = skid_load ? IN_DATA : skid_q;
        ready_d = (state_d != ST_FULL);
      end

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          skid_q  <= '0;
          ready_q <= 1'b1;
        end else begin
          skid_q  <= skid_d;
          ready_q <= ready_d;
        end
      end

      assign IN_READY  = ready_q;
      assign skid_data = skid_q;
    end else begin : g_comb
      assign IN_READY  = ~OUT_VALID | OUT_READY;
      assign skid_data = '0;
    end
  endgenerate

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .CLK  (CLK),
    .RST_N(RST_N),
    .INC  (stall_inc),
    .COUNT(STALL_CNT)
  );

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Self-checking bench: skid, non-skid and 4-bit-counter instances share one stimulus
// stream and are compared against queue-based reference models.
module tb_pipe_stage_buffer;

  localparam int W  = 16;
  localparam int F  = 5;
  localparam int DW = W * F;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;

  logic          rdy_s, ov_s, rdy_n, ov_n, rdy_c, ov_c;
  logic [DW-1:0] od_s, od_n, od_c;
  logic [15:0]   cnt_s, cnt_n;
  logic [3:0]    cnt_c;

  always #5 clk = ~clk;

  pipe_stage_buffer #(.WIDTH(W), .FIELDS(F), .SKID(1), .CNT_W(16)) dut_s (
    .CLK(clk), .RST_N(rst_n), .FLUSH(flush), .IN_VALID(in_valid), .IN_READY(rdy_s),
    .IN_DATA(in_data), .OUT_VALID(ov_s), .OUT_READY(out_ready), .OUT_DATA(od_s), .STALL_CNT(cnt_s));

  pipe_stage_buffer #(.WIDTH(W), .FIELDS(F), .SKID(0), .CNT_W(16)) dut_n (
    .CLK(clk), .RST_N(rst_n), .FLUSH(flush), .IN_VALID(in_valid), .IN_READY(rdy_n),
    .IN_DATA(in_data), .OUT_VALID(ov_n), .OUT_READY(out_ready), .OUT_DATA(od_n), .STALL_CNT(cnt_n));

  pipe_stage_buffer #(.WIDTH(W), .FIELDS(F), .SKID(1), .CNT_W(4)) dut_c (
    .CLK(clk), .RST_N(rst_n), .FLUSH(flush), .IN_VALID(in_valid), .IN_READY(rdy_c),
    .IN_DATA(in_data), .OUT_VALID(ov_c), .OUT_READY(out_ready), .OUT_DATA(od_c), .STALL_CNT(cnt_c));

  // Reference model: a FIFO of capacity 2 (skid) or 1 (non-skid), the last head shown,
  // and an unbounded stall tally that is saturated only when compared.
  logic [DW-1:0] qs[$];
  logic [DW-1:0] qn[$];
  logic [DW-1:0] ms, mn;
  int unsigned   ss, sn;

  int checks = 0;
  int errors = 0;
  string phase = "init";

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s observed=%h expected=%h", phase, tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rep(input logic [15:0] v);
    return {F{v}};
  endfunction

  function automatic logic [DW-1:0] sat(input int unsigned v, input int unsigned maxv);
    return DW'((v > maxv) ? maxv : v);
  endfunction

  task automatic model_reset();
    qs.delete(); qn.delete();
    ms = '0; mn = '0; ss = 0; sn = 0;
  endtask

  task automatic check_all();
    chk("s.in_ready",  DW'(qs.size() < 2), DW'(rdy_s));
    chk("s.out_valid", DW'(ov_s), DW'(qs.size() > 0));
    chk("s.out_data",  od_s, (qs.size() > 0) ? qs[0] : ms);
    chk("s.stall_cnt", DW'(cnt_s), sat(ss, 65535));
    chk("n.in_ready",  DW'(rdy_n), DW'((qn.size() == 0) || out_ready));
    chk("n.out_valid", DW'(ov_n), DW'(qn.size() > 0));
    chk("n.out_data",  od_n, (qn.size() > 0) ? qn[0] : mn);
    chk("n.stall_cnt", DW'(cnt_n), sat(sn, 65535));
    chk("c.out_data",  od_c, (qs.size() > 0) ? qs[0] : ms);
    chk("c.stall_cnt", DW'(cnt_c), sat(ss, 15));
  endtask

  task automatic model_edge();
    bit ov, acc, pop;
    if (!rst_n) begin
      model_reset();
    end else begin
      ov  = (qs.size() > 0);
      acc = in_valid && (qs.size() < 2);
      pop = ov && out_ready;
      if (ov && !out_ready) ss++;
      if (flush) qs.delete();
      else begin
        if (pop) void'(qs.pop_front());
        if (acc) qs.push_back(in_data);
      end
      if (qs.size() > 0) ms = qs[0];

      ov  = (qn.size() > 0);
      acc = in_valid && ((qn.size() == 0) || out_ready);
      pop = ov && out_ready;
      if (ov && !out_ready) sn++;
      if (flush) qn.delete();
      else begin
        if (pop) void'(qn.pop_front());
        if (acc) qn.push_back(in_data);
      end
      if (qn.size() > 0) mn = qn[0];
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    logic [95:0] r;
    model_reset();

    phase = "reset";
    repeat (2) step();
    chk("reset.s.out_data", od_s, '0);
    rst_n = 1'b1;

    phase = "stream";
    out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      in_valid = 1'b1;
      in_data  = rep(16'(k));
      step();
    end
    in_valid = 1'b0;
    repeat (2) step();

    phase = "stall";
    in_valid = 1'b1; in_data = rep(16'hAAAA); out_ready = 1'b1;
    step();
    in_data = rep(16'hBBBB); out_ready = 1'b0;
    repeat (4) step();
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();

    phase = "flush";
    in_valid = 1'b1; in_data = rep(16'h1111); out_ready = 1'b0;
    step();
    in_data = rep(16'h2222);
    step();
    flush = 1'b1; in_data = rep(16'h3333); out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    repeat (3) step();

    phase = "async_reset";
    in_valid = 1'b1; in_data = rep(16'h4444); out_ready = 1'b0;
    step();
    in_data = rep(16'h5555);
    repeat (2) step();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid.s.out_valid", DW'(ov_s), '0);
    chk("mid.s.out_data",  od_s, '0);
    chk("mid.s.stall_cnt", DW'(cnt_s), '0);
    chk("mid.s.in_ready",  DW'(rdy_s), DW'(1));
    chk("mid.c.stall_cnt", DW'(cnt_c), '0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;

    phase = "saturate";
    in_valid = 1'b1; in_data = rep(16'h7777); out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (21) step();
    chk("sat.c.stall_cnt", DW'(cnt_c), DW'(15));
    out_ready = 1'b1;
    repeat (2) step();

    phase = "random";
    for (int i = 0; i < 400; i++) begin
      r         = {$urandom, $urandom, $urandom};
      in_data   = r[DW-1:0];
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < ((i % 100) < 30 ? 2 : 6));
      flush     = ($urandom_range(0, 19) == 0);
      step();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buffer.md
# pipe_stage_buffer

Parametrised pipeline-stage register that replaces fixed-width stage buffers such as the MEM/WB latch. It carries FIELDS packed fields of WIDTH bits each, using a valid/ready handshake with synchronous flush. An optional two-entry skid mode gives full throughput with a registered IN_READY. A saturating stall counter supports performance debug.

## Interface
- WIDTH, 16: bits per field.
- FIELDS, 5: number of packed fields; DW = WIDTH*FIELDS.
- SKID, 1: 1 = two-entry skid buffer with registered IN_READY; 0 = single register with combinational IN_READY.
- CNT_W, 16: width of the stall counter.
- CLK  in  1  clock, all state updates on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- FLUSH  in  1  synchronous discard of all held entries.
- IN_VALID  in  1  upstream entry present.
- IN_READY  out  1  buffer can accept this cycle.
- IN_DATA  in  DW  field k at bits [k*WIDTH +: WIDTH].
- OUT_VALID  out  1  entry present at output.
- OUT_READY  in  1  downstream takes the entry this cycle.
- OUT_DATA  out  DW  head entry, same packing as IN_DATA.
- STALL_CNT  out  CNT_W  saturating count of cycles with OUT_VALID=1 and OUT_READY=0.

## Operation
- A transfer occurs on an edge where VALID and READY are both 1. `acc` = IN_VALID & IN_READY; `pop` = OUT_VALID & OUT_READY.
- State is {EMPTY, ONE, FULL}. FULL exists only when SKID=1. Storage is a main register (drives OUT_DATA) and, when SKID=1, a skid register.
- EMPTY: acc → ONE, main <= IN_DATA.
- ONE: acc&pop → ONE, main <= IN_DATA. acc&!pop → FULL, skid <= IN_DATA (SKID=1 only). !acc&pop → EMPTY. Otherwise hold.
- FULL: pop → ONE, main <= skid. Otherwise hold. IN_READY is 0, so acc cannot occur.
- IN_READY:
  - SKID=1: IN_READY = (state != FULL), taken from a register.
  - SKID=0: IN_READY = !OUT_VALID | OUT_READY, combinational. acc&!pop therefore cannot occur in ONE.
- OUT_VALID = (state != EMPTY). OUT_DATA = main register, which holds its last value while EMPTY.
- FLUSH has priority over everything else:
  - Next state is EMPTY.
  - Any acc or pop in the flush cycle is dropped from buffer state; upstream still sees its handshake complete.
  - Data registers are not cleared.
- STALL_CNT increments when OUT_VALID & !OUT_READY, including in the FLUSH cycle. It saturates at all-ones. It is cleared only by reset.
- Field packing is positional only; the block never interprets field contents.

## Timing
- Reset (RST_N=0, asynchronous assert, synchronous release):
  - state = EMPTY, OUT_VALID = 0, OUT_DATA = 0, skid = 0, STALL_CNT = 0.
  - IN_READY = 1 in both modes.
- Latency: IN_DATA accepted at edge n appears on OUT_DATA after edge n, with OUT_VALID=1 in cycle n+1.
- Throughput: one entry per cycle in both modes while OUT_READY=1.
- SKID=1, stall: the entry accepted during the first stalled cycle goes to skid. IN_READY drops in the following cycle. It rises one cycle after the pop that empties skid.
- Ordering is strict FIFO; entries are never duplicated or reordered.
- RST_N asserted mid-transfer: all held entries are lost immediately and outputs take their reset values without waiting for CLK.

## Structure
- Shared package `pipe_buf_pkg`:
  - state encoding localparams ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_FULL = 2'd2;
  - the helper function that computes DW.
- Sub-module `sat_counter` (parameter CNT_W; ports CLK, RST_N, INC, COUNT) implements STALL_CNT.
- SKID selects its logic through a generate branch; there is no separate module per mode.
- Target size is about 150–250 lines of RTL.

## Test plan
- Reset, then stream 0x0001..0x0005 into all fields with OUT_READY=1 held high → OUT_DATA shows 0x0001..0x0005 on consecutive cycles, each one cycle after acceptance; STALL_CNT = 0.
- SKID=1: load A=0xAAAA, hold OUT_READY=0, present B=0xBBBB → B accepted into skid. IN_READY=0 next cycle. STALL_CNT increments each stalled cycle. Release → A then B, no loss.
- SKID=0, same stimulus → B is not accepted while OUT_READY=0 (IN_READY=0 in the same cycle). A is held. B is accepted in the cycle OUT_READY returns to 1.
- FULL plus FLUSH with IN_VALID=1 and OUT_READY=1 in the same cycle → next cycle OUT_VALID=0 and IN_READY=1; neither entry nor the new input ever appears at the output.
- Drop RST_N between clock edges while FULL → OUT_VALID=0, OUT_DATA=0 and STALL_CNT=0 immediately, before the next edge.
- CNT_W=4: stall 20 cycles → STALL_CNT = 15, stays at 15.
